// File: rtl/m72_pic_pkg.sv
// m72_pic_pkg: shared types and constants for the M72 interrupt controller.
//   state_t        initialisation / operating state of the controller
//   *_BIT / *_SEL  command-word bit positions (ICW1, ICW4, OCW2, OCW3)
//   SPURIOUS_IRQ   vector index returned when nothing is pending
//   make_vector    builds the 8-bit vector from base and level
package m72_pic_pkg;

  localparam int unsigned IRQ_W    = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned BASE_W   = 5;
  localparam int unsigned BASE_LSB = 3;

  typedef enum logic [2:0] {
    ST_UNINIT = 3'd0,
    ST_ICW2   = 3'd1,
    ST_ICW3   = 3'd2,
    ST_ICW4   = 3'd3,
    ST_READY  = 3'd4
  } state_t;

  // ICW1 (a1=0): bit 4 marks the word as ICW1
  localparam int unsigned ICW1_SEL_BIT  = 4;
  localparam int unsigned ICW1_SNGL_BIT = 1;
  localparam int unsigned ICW1_IC4_BIT  = 0;

  // ICW4 (a1=1 during init)
  localparam int unsigned ICW4_AEOI_BIT = 1;

  // OCW selector field din[4:3] for a1=0 writes
  localparam int unsigned OCW_SEL_HI = 4;
  localparam int unsigned OCW_SEL_LO = 3;
  localparam logic [1:0]  OCW_SEL_OCW2 = 2'b00;
  localparam logic [1:0]  OCW_SEL_OCW3 = 2'b01;

  // OCW2
  localparam int unsigned OCW2_EOI_BIT = 5;
  localparam int unsigned OCW2_SL_BIT  = 6;

  // OCW3
  localparam int unsigned OCW3_ERIS_BIT = 1;
  localparam int unsigned OCW3_RIS_BIT  = 0;

  localparam logic [IDX_W-1:0] SPURIOUS_IRQ = 3'd7;

  function automatic logic [IRQ_W-1:0] make_vector(input logic [BASE_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
    return {base, idx};
  endfunction

endpackage : m72_pic_pkg

// File: rtl/m72_pic_if.sv
// m72_pic_if: CPU-side bus of the interrupt controller.
//   cs/a1/we/stb/din  I/O access (INTCS decode, register select, strobe)
//   dout              read data, or the vector while vec_valid is high
//   irq               raw request lines (pixel clock domain)
//   int_rq/int_ack    request to CPU / acknowledge indication (wb_tgc)
//   vec_valid         dout carries a vector
interface m72_pic_if;
  import m72_pic_pkg::*;

  logic             cs;
  logic             a1;
  logic             we;
  logic             stb;
  logic [IRQ_W-1:0] din;
  logic [IRQ_W-1:0] dout;
  logic [IRQ_W-1:0] irq;
  logic             int_rq;
  logic             int_ack;
  logic             vec_valid;

  modport master (
    output cs, a1, we, stb, din, irq, int_ack,
    input  dout, int_rq, vec_valid
  );

  modport slave (
    input  cs, a1, we, stb, din, irq, int_ack,
    output dout, int_rq, vec_valid
  );

endinterface : m72_pic_if

// File: rtl/m72_pic_prio.sv
// m72_pic_prio: lowest-set-bit encoder (bit 0 has highest priority).
//   i_vec  request/service vector
//   o_idx  index of the lowest set bit (0 when none set)
//   o_any  at least one bit set
module m72_pic_prio
  import m72_pic_pkg::*;
(
  input  logic [IRQ_W-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    o_idx = '0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_any = |i_vec;

endmodule : m72_pic_prio

// File: rtl/m72_pic.sv
// m72_pic: simplified 8259-style interrupt controller for the M72 main CPU.
//   i_clock    system clock
//   i_reset_n  asynchronous active-low reset
//   io_bus     CPU bus, request lines and acknowledge (m72_pic_if.slave)
// Edge-triggered requests, mask, in-service tracking, fixed priority with
// IRQ0 highest, vector supply on acknowledge.
module m72_pic
  import m72_pic_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [IRQ_W-1:0] RESET_IMR   = 8'hFF
) (
  input  logic     i_clock,
  input  logic     i_reset_n,
  m72_pic_if.slave io_bus
);

  state_t r_state;
  state_t w_state_n;

  logic [IRQ_W-1:0]  r_irq_sync [SYNC_STAGES];
  logic [IRQ_W-1:0]  r_irq_d;
  logic [IRQ_W-1:0]  w_irq_rise;

  logic              r_stb_d;
  logic              w_start;
  logic              w_wr;
  logic              w_ack;

  logic [IRQ_W-1:0]  r_irr, w_irr_n;
  logic [IRQ_W-1:0]  r_isr, w_isr_n;
  logic [IRQ_W-1:0]  r_imr, w_imr_n;
  logic [BASE_W-1:0] r_base, w_base_n;
  logic              r_aeoi, w_aeoi_n;
  logic              r_rr_sel, w_rr_sel_n;
  logic              r_need_icw3, w_need_icw3_n;
  logic              r_need_icw4, w_need_icw4_n;
  logic [IRQ_W-1:0]  r_vec, w_vec_n;
  logic              r_vec_valid, w_vec_valid_n;
  logic              r_int_rq, w_int_rq_n;

  logic [IRQ_W-1:0]  w_pend;
  logic [IDX_W-1:0]  w_pend_idx;
  logic              w_pend_any;
  logic [IDX_W-1:0]  w_isr_idx;
  logic              w_isr_any;

  logic              w_ack_set;
  logic [IDX_W-1:0]  w_eoi_idx;
  logic              w_eoi_any;
  logic [1:0]        w_ocw_sel;
  logic [IRQ_W-1:0]  w_dout;

  // Request synchronizer from the pixel clock domain plus edge-detect stage
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_irq_sync[i] <= '0;
      r_irq_d <= '0;
    end else begin
      r_irq_sync[0] <= io_bus.irq;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_irq_sync[i] <= r_irq_sync[i-1];
      r_irq_d <= r_irq_sync[SYNC_STAGES-1];
    end
  end

  assign w_irq_rise = r_irq_sync[SYNC_STAGES-1] & ~r_irq_d;

  // Strobe is held several clocks; each access commits only on its first one
  assign w_start = io_bus.stb & ~r_stb_d;
  assign w_wr    = io_bus.cs & io_bus.we & w_start;
  assign w_ack   = io_bus.int_ack & w_start;

  assign w_pend = r_irr & ~r_imr;

  m72_pic_prio u_prio_pend (
    .i_vec (w_pend),
    .o_idx (w_pend_idx),
    .o_any (w_pend_any)
  );

  m72_pic_prio u_prio_isr (
    .i_vec (r_isr),
    .o_idx (w_isr_idx),
    .o_any (w_isr_any)
  );

  // A same-cycle ack is applied before EOI, so the EOI target must see the
  // bit the ack is about to set without a third encoder.
  assign w_ack_set = w_ack & w_pend_any & ~r_aeoi;
  assign w_eoi_idx = (w_ack_set && (!w_isr_any || (w_pend_idx < w_isr_idx)))
                     ? w_pend_idx : w_isr_idx;
  assign w_eoi_any = w_ack_set | w_isr_any;
  assign w_ocw_sel = io_bus.din[OCW_SEL_HI:OCW_SEL_LO];

  // Next-state and register update logic
  always_comb begin
    w_state_n     = r_state;
    w_irr_n       = r_irr;
    w_isr_n       = r_isr;
    w_imr_n       = r_imr;
    w_base_n      = r_base;
    w_aeoi_n      = r_aeoi;
    w_rr_sel_n    = r_rr_sel;
    w_need_icw3_n = r_need_icw3;
    w_need_icw4_n = r_need_icw4;
    w_vec_n       = r_vec;
    w_vec_valid_n = r_vec_valid;
    w_int_rq_n    = (r_state == ST_READY) & w_pend_any &
                    (~w_isr_any | (w_pend_idx < w_isr_idx));

    // Acknowledge: latch vector, retire the request
    if (w_ack) begin
      w_vec_valid_n = 1'b1;
      if (w_pend_any) begin
        w_vec_n             = make_vector(r_base, w_pend_idx);
        w_irr_n[w_pend_idx] = 1'b0;
        if (!r_aeoi) w_isr_n[w_pend_idx] = 1'b1;
      end else begin
        w_vec_n = make_vector(r_base, SPURIOUS_IRQ);
      end
    end else if (r_vec_valid && !io_bus.stb) begin
      w_vec_valid_n = 1'b0;
    end

    // A new edge outranks the ack clear of the same bit
    w_irr_n = w_irr_n | w_irq_rise;

    if (w_wr) begin
      if (!io_bus.a1 && io_bus.din[ICW1_SEL_BIT]) begin
        w_irr_n       = '0;
        w_isr_n       = '0;
        w_imr_n       = RESET_IMR;
        w_need_icw3_n = ~io_bus.din[ICW1_SNGL_BIT];
        w_need_icw4_n = io_bus.din[ICW1_IC4_BIT];
        w_state_n     = ST_ICW2;
      end else if (io_bus.a1) begin
        unique case (r_state)
          ST_ICW2: begin
            w_base_n  = io_bus.din[IRQ_W-1:BASE_LSB];
            w_state_n = r_need_icw3 ? ST_ICW3 : (r_need_icw4 ? ST_ICW4 : ST_READY);
          end
          ST_ICW3: w_state_n = r_need_icw4 ? ST_ICW4 : ST_READY;
          ST_ICW4: begin
            w_aeoi_n  = io_bus.din[ICW4_AEOI_BIT];
            w_state_n = ST_READY;
          end
          ST_READY: w_imr_n = io_bus.din;
          default: ;
        endcase
      end else if ((r_state == ST_READY) || (r_state == ST_UNINIT)) begin
        if ((w_ocw_sel == OCW_SEL_OCW2) && io_bus.din[OCW2_EOI_BIT]) begin
          if (io_bus.din[OCW2_SL_BIT]) begin
            w_isr_n[io_bus.din[IDX_W-1:0]] = 1'b0;
          end else if (w_eoi_any) begin
            w_isr_n[w_eoi_idx] = 1'b0;
          end
        end else if ((w_ocw_sel == OCW_SEL_OCW3) && io_bus.din[OCW3_ERIS_BIT]) begin
          w_rr_sel_n = io_bus.din[OCW3_RIS_BIT];
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_UNINIT;
    else            r_state <= w_state_n;
  end

  // Datapath registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stb_d     <= 1'b0;
      r_irr       <= '0;
      r_isr       <= '0;
      r_imr       <= RESET_IMR;
      r_base      <= '0;
      r_aeoi      <= 1'b0;
      r_rr_sel    <= 1'b0;
      r_need_icw3 <= 1'b0;
      r_need_icw4 <= 1'b0;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
      r_int_rq    <= 1'b0;
    end else begin
      r_stb_d     <= io_bus.stb;
      r_irr       <= w_irr_n;
      r_isr       <= w_isr_n;
      r_imr       <= w_imr_n;
      r_base      <= w_base_n;
      r_aeoi      <= w_aeoi_n;
      r_rr_sel    <= w_rr_sel_n;
      r_need_icw3 <= w_need_icw3_n;
      r_need_icw4 <= w_need_icw4_n;
      r_vec       <= w_vec_n;
      r_vec_valid <= w_vec_valid_n;
      r_int_rq    <= w_int_rq_n;
    end
  end

  // Read data is combinational so it is valid for the whole strobe
  always_comb begin
    w_dout = '0;
    if (r_vec_valid) begin
      w_dout = r_vec;
    end else if (io_bus.cs && !io_bus.we) begin
      w_dout = io_bus.a1 ? r_imr : (r_rr_sel ? r_isr : r_irr);
    end
  end

  assign io_bus.dout      = w_dout;
  assign io_bus.int_rq    = r_int_rq;
  assign io_bus.vec_valid = r_vec_valid;

endmodule : m72_pic

// File: tb/tb_m72_pic.sv
// tb_m72_pic: directed walk through the controller's main scenarios followed
// by a randomized phase, all checked against a behavioural model.
module tb_m72_pic;

  logic clk = 1'b0;
  logic rst_n;

  m72_pic_if bus ();

  m72_pic #(
    .SYNC_STAGES (2),
    .RESET_IMR   (8'hFF)
  ) u_dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state
  localparam int MS_UNINIT = 0;
  localparam int MS_ICW2   = 2;
  localparam int MS_ICW3   = 3;
  localparam int MS_ICW4   = 4;
  localparam int MS_READY  = 5;

  logic [7:0] m_irr, m_isr, m_imr;
  logic [4:0] m_base;
  bit         m_aeoi, m_rrsel, m_need3, m_need4;
  int         m_st;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  // Request rule: an unmasked request outranks everything in service
  function automatic logic exp_int_rq();
    return (m_st == MS_READY) && (lowest(m_irr & ~m_imr) < lowest(m_isr));
  endfunction

  task automatic m_reset();
    m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_base = 0;
    m_aeoi = 0; m_rrsel = 0; m_need3 = 0; m_need4 = 0; m_st = MS_UNINIT;
  endtask

  task automatic m_write(input logic a1, input logic [7:0] d);
    if (!a1 && d[4]) begin
      m_irr = 0; m_isr = 0; m_imr = 8'hFF;
      m_need3 = !d[1]; m_need4 = d[0]; m_st = MS_ICW2;
    end else if (a1) begin
      case (m_st)
        MS_ICW2: begin
          m_base = d[7:3];
          m_st = m_need3 ? MS_ICW3 : (m_need4 ? MS_ICW4 : MS_READY);
        end
        MS_ICW3:  m_st = m_need4 ? MS_ICW4 : MS_READY;
        MS_ICW4:  begin m_aeoi = d[1]; m_st = MS_READY; end
        MS_READY: m_imr = d;
        default: ;
      endcase
    end else if (m_st == MS_READY || m_st == MS_UNINIT) begin
      if (d[4:3] == 2'b00 && d[5]) begin
        if (d[6]) m_isr[d[2:0]] = 1'b0;
        else if (m_isr != 0) m_isr[lowest(m_isr)] = 1'b0;
      end else if (d[4:3] == 2'b01 && d[1]) begin
        m_rrsel = d[0];
      end
    end
  endtask

  function automatic logic [7:0] m_ack();
    int p;
    p = lowest(m_irr & ~m_imr);
    if (p == 8) return {m_base, 3'd7};
    m_irr[p] = 1'b0;
    if (!m_aeoi) m_isr[p] = 1'b1;
    return m_base * 8 + p;
  endfunction

  task automatic bus_idle();
    bus.cs = 0; bus.we = 0; bus.a1 = 0; bus.stb = 0; bus.din = 0; bus.int_ack = 0;
  endtask

  task automatic bus_write(input logic a1, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cs = 1; bus.we = 1; bus.a1 = a1; bus.din = d; bus.stb = 1;
    repeat (3) @(posedge clk);
    #1 bus_idle();
    repeat (2) @(posedge clk);
    m_write(a1, d);
  endtask

  task automatic bus_read(input string tag, input logic a1, input logic [7:0] exp);
    @(posedge clk); #1;
    bus.cs = 1; bus.we = 0; bus.a1 = a1; bus.stb = 1;
    @(negedge clk);
    check_eq(tag, bus.dout, exp);
    repeat (2) @(posedge clk);
    #1 bus_idle();
    @(posedge clk);
  endtask

  task automatic read_sel(input string tag);
    bus_read(tag, 1'b0, m_rrsel ? m_isr : m_irr);
  endtask

  task automatic read_irr(input string tag);
    bus_write(1'b0, 8'h0A);
    bus_read(tag, 1'b0, m_irr);
  endtask

  task automatic read_isr(input string tag);
    bus_write(1'b0, 8'h0B);
    bus_read(tag, 1'b0, m_isr);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    @(posedge clk); #1 bus.irq = m;
    repeat (2) @(posedge clk);
    #1 bus.irq = 0;
    repeat (6) @(posedge clk);
    m_irr = m_irr | m;
  endtask

  task automatic check_int(input string tag);
    @(negedge clk);
    check_eq(tag, bus.int_rq, exp_int_rq());
  endtask

  // race=1 times a fresh irq[0] edge to land on the acknowledge cycle
  task automatic bus_ack(input string tag, input bit race, output logic [7:0] vec);
    logic [7:0] exp;
    exp = m_ack();
    if (race) begin
      @(posedge clk); #1 bus.irq[0] = 1'b1;
      @(posedge clk);
    end
    @(posedge clk); #1;
    bus.int_ack = 1; bus.stb = 1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_vv"}, bus.vec_valid, 1'b1);
    check_eq(tag, bus.dout, exp);
    vec = bus.dout;
    @(posedge clk); #1;
    bus.stb = 0; bus.int_ack = 0; bus.irq = 0;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_vv_clr"}, bus.vec_valid, 1'b0);
    repeat (6) @(posedge clk);
    if (race) m_irr[0] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] msk;
    int op;

    rst_n = 0;
    bus.irq = 0;
    bus_idle();
    m_reset();
    #23 rst_n = 1;

    // Reset state
    @(negedge clk);
    check_eq("rst_int_rq", bus.int_rq, 1'b0);
    check_eq("rst_vec_valid", bus.vec_valid, 1'b0);
    check_eq("rst_dout", bus.dout, 8'h00);
    bus_read("rst_imr", 1'b1, 8'hFF);
    read_sel("rst_irr");

    // Init and first interrupt
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'h20);
    bus_write(1'b1, 8'h01);
    bus_write(1'b1, 8'hFA);
    check_int("init_idle_int_rq");
    pulse_irq(8'h01);
    check_int("irq0_int_rq");
    check_eq("irq0_int_rq_hi", bus.int_rq, 1'b1);
    bus_ack("ack_irq0", 0, v);
    check_eq("vec_irq0_lit", v, 8'h20);
    read_isr("isr_after_ack0");
    check_int("int_rq_after_ack0");

    // Nesting: lower-priority request waits for EOI
    pulse_irq(8'h04);
    check_int("irq2_blocked");
    bus_write(1'b0, 8'h20);
    check_int("irq2_after_eoi");
    bus_ack("ack_irq2", 0, v);
    check_eq("vec_irq2_lit", v, 8'h22);
    bus_write(1'b0, 8'h20);

    // Masking
    bus_write(1'b1, 8'hFF);
    pulse_irq(8'h01);
    check_int("masked_int_rq");
    read_irr("masked_irr");
    bus_write(1'b1, 8'hFE);
    check_int("unmasked_int_rq");

    // Automatic EOI
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'h20);
    bus_write(1'b1, 8'h03);
    bus_write(1'b1, 8'hFE);
    pulse_irq(8'h01);
    bus_ack("ack_aeoi", 0, v);
    read_isr("isr_aeoi");

    // Spurious acknowledge
    bus_ack("ack_spurious", 0, v);
    check_eq("vec_spurious_lit", v, 8'h27);
    read_irr("irr_spurious");
    read_isr("isr_spurious");

    // New edge in the acknowledge cycle keeps the request pending
    pulse_irq(8'h01);
    bus_ack("ack_race", 1, v);
    read_irr("irr_race");
    check_int("int_rq_race");

    // Reset during an active vector
    @(posedge clk); #1;
    bus.int_ack = 1; bus.stb = 1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_vv_pre", bus.vec_valid, 1'b1);
    check_eq("rst_mid_int_pre", bus.int_rq, 1'b1);
    #2 rst_n = 0;
    #1;
    check_eq("rst_mid_vv", bus.vec_valid, 1'b0);
    check_eq("rst_mid_int_rq", bus.int_rq, 1'b0);
    check_eq("rst_mid_dout", bus.dout, 8'h00);
    bus_idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    m_reset();
    bus_read("rst_mid_imr", 1'b1, 8'hFF);

    // Reinit while requests are pending
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'h20);
    bus_write(1'b1, 8'h01);
    bus_write(1'b1, 8'hFA);
    pulse_irq(8'h05);
    read_sel("irr_pre_reinit");
    check_int("int_rq_pre_reinit");
    bus_write(1'b0, 8'h11);
    check_int("reinit_icw2_int_rq");
    read_sel("reinit_irr");
    bus_read("reinit_imr", 1'b1, 8'hFF);
    bus_write(1'b1, 8'h40);
    check_int("reinit_icw3_int_rq");
    bus_write(1'b1, 8'h00);
    check_int("reinit_icw4_int_rq");
    bus_write(1'b1, 8'h01);
    check_int("reinit_ready_int_rq");

    // Randomized operation mix
    bus_write(1'b1, 8'h00);
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          msk = 8'($urandom);
          pulse_irq(msk);
        end
        1: bus_ack("rnd_ack", 0, v);
        2: bus_write(1'b0, 8'h20);
        3: bus_write(1'b0, 8'(8'h60 | $urandom_range(0, 7)));
        4: bus_write(1'b1, 8'($urandom) & 8'($urandom));
        default: begin
          case ($urandom_range(0, 2))
            0: read_irr("rnd_irr");
            1: read_isr("rnd_isr");
            default: bus_read("rnd_imr", 1'b1, m_imr);
          endcase
        end
      endcase
      check_int("rnd_int_rq");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_m72_pic
